button_hub: RTL and testbench

Parametrised front end for all push-button input: it synchronises, debounces and edge-shapes `NUM_BUTTONS` raw buttons and steers the resulting one-cycle press pulses to one of `NUM_DEST` consumers (access control, game, scoreboard, …). Each channel can also auto-repeat while held. Consumer switching is deferred while any button is held, so a press is never split across consumers. It replaces the per-button shaper plus fixed 3-way decoder at the top level.

---
 rtl/button_hub_pkg.sv | 25 ++
 rtl/button_channel.sv | 115 +++++++++++
 rtl/button_hub.sv | 68 ++++++
 tb/tb_button_hub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/button_hub_pkg.sv
// Shared types and helpers for the push-button front end.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package button_hub_pkg;

  // Per-channel press state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } ch_state_t;

  // Polarity inside the hub, after the raw pin has been normalised
  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce, press/repeat FSM, repeat timer.
// Latency: level and press pulse appear 2+DEBOUNCE_CYCLES cycles after a clean input change.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
// Ports: btn_raw (async pin), repeat_en (auto-repeat enable), level (debounced, 1=pressed),
//        pulse (one-cycle press / repeat strobe).
module button_channel
  import button_hub_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int ACTIVE_LOW_IN   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic pulse
);

  localparam int CNT_W   = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = clog2_min1(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOAD_DELAY  = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] LOAD_PERIOD = TMR_W'(REPEAT_PERIOD);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

  // Normalise polarity before the synchroniser so its reset value means "released"
  logic raw_pressed;
  assign raw_pressed = (ACTIVE_LOW_IN != 0) ? ~btn_raw : btn_raw;

  logic             sync_q;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             toggle;
  logic             rise;
  logic             fall;

  assign toggle = (s != level) && (cnt == CNT_LAST);
  assign rise   = toggle && (level == RELEASED);
  assign fall   = toggle && (level == PRESSED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= RELEASED;
      s      <= RELEASED;
      cnt    <= '0;
      level  <= RELEASED;
    end else begin
      sync_q <= raw_pressed;
      s      <= sync_q;
      if ((s == level) || toggle) cnt <= '0;
      else                        cnt <= cnt + 1'b1;
      if (toggle) level <= ~level;
    end
  end

  ch_state_t        state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             pulse_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      pulse <= pulse_nxt;
    end
  end

  // The pulse is registered on the same edge that flips level, so both line up.
  // Timer expiry is detected at 1 so the strobe lands exactly N cycles after the load.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pulse_nxt = 1'b0;
    if (fall) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HELD;
            timer_nxt = LOAD_DELAY;
            pulse_nxt = 1'b1;
          end
        end
        HELD, REPEAT: begin
          if (!repeat_en) begin
            state_nxt = HELD;
            timer_nxt = LOAD_DELAY;
          end else if (timer <= TMR_ONE) begin
            state_nxt = REPEAT;
            timer_nxt = LOAD_PERIOD;
            pulse_nxt = 1'b1;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_hub.sv
// Push-button front end: per-channel conditioning plus steering of press pulses to one consumer.
// Latency: press pulse 2+DEBOUNCE_CYCLES cycles after a clean press; consumer switch 1 cycle after all released.
// Backpressure: none; consumer switch is deferred while any button is held.
// Ports: btn_raw/repeat_en per channel, dest_sel request; btn_pulse (consumer-major, channel-minor),
//        btn_level, active_dest, dest_pending, dest_valid.
module button_hub
  import button_hub_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int NUM_DEST        = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int ACTIVE_LOW_IN   = 1,
  parameter int SEL_W           = clog2_min1(NUM_DEST)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BUTTONS-1:0]        btn_raw,
  input  logic [NUM_BUTTONS-1:0]        repeat_en,
  input  logic [SEL_W-1:0]              dest_sel,
  output logic [NUM_DEST*NUM_BUTTONS-1:0] btn_pulse,
  output logic [NUM_BUTTONS-1:0]        btn_level,
  output logic [SEL_W-1:0]              active_dest,
  output logic                          dest_pending,
  output logic                          dest_valid
);

  logic [NUM_BUTTONS-1:0] ch_pulse;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .repeat_en (repeat_en[i]),
      .level     (btn_level[i]),
      .pulse     (ch_pulse[i])
    );
  end

  assign dest_pending = (dest_sel != active_dest);
  assign dest_valid   = (int'(active_dest) < NUM_DEST);

  // Only switch when nothing is held, so a press and its repeats stay with one consumer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_dest <= '0;
    end else if (dest_pending && (btn_level == '0)) begin
      active_dest <= dest_sel;
    end
  end

  always_comb begin
    btn_pulse = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      if (dest_valid && (active_dest == SEL_W'(d))) begin
        btn_pulse[d*NUM_BUTTONS +: NUM_BUTTONS] = ch_pulse;
      end
    end
  end

endmodule

// File: tb/tb_button_hub.sv
// Directed bench for button_hub: vector table plus hand sequences for repeat, switch and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_hub;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] repeat_en;
  logic [1:0] dest_sel;
  logic [8:0] btn_pulse;
  logic [2:0] btn_level;
  logic [1:0] active_dest;
  logic       dest_pending;
  logic       dest_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_hub #(
    .NUM_BUTTONS     (3),
    .NUM_DEST        (3),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .ACTIVE_LOW_IN   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .repeat_en    (repeat_en),
    .dest_sel     (dest_sel),
    .btn_pulse    (btn_pulse),
    .btn_level    (btn_level),
    .active_dest  (active_dest),
    .dest_pending (dest_pending),
    .dest_valid   (dest_valid)
  );

  typedef struct {
    string      name;
    logic [2:0] raw;
    logic [2:0] ren;
    logic [1:0] sel;
    int         n;
    logic [8:0] pulse;
    logic [2:0] level;
    logic [1:0] act;
    logic       pend;
    logic       valid;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic [2:0] raw, input logic [2:0] ren,
                              input logic [1:0] sel, input int n, input logic [8:0] pulse,
                              input logic [2:0] level, input logic [1:0] act, input logic pend,
                              input logic valid);
    vec_t v;
    v.name = name; v.raw = raw; v.ren = ren; v.sel = sel; v.n = n;
    v.pulse = pulse; v.level = level; v.act = act; v.pend = pend; v.valid = valid;
    tbl.push_back(v);
  endfunction

  function automatic logic [15:0] pack_exp(input logic [8:0] pulse, input logic [2:0] level,
                                           input logic [1:0] act, input logic pend, input logic valid);
    return {pulse, level, act, pend, valid};
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] got;
    got = {btn_pulse, btn_level, active_dest, dest_pending, dest_valid};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got pulse=%b level=%b act=%0d pend=%b valid=%b, want pulse=%b level=%b act=%0d pend=%b valid=%b",
                  name, got[15:7], got[6:4], got[3:2], got[1], got[0],
                  exp[15:7], exp[6:4], exp[3:2], exp[1], exp[0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Clean press of button 1 on consumer 2, then release
    add("press",        3'b101, 3'b000, 2'd2, 5, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    add("press_edge",   3'b101, 3'b000, 2'd2, 1, 9'h080, 3'b010, 2'd2, 1'b0, 1'b1);
    add("press_held",   3'b101, 3'b000, 2'd2, 3, 9'h000, 3'b010, 2'd2, 1'b0, 1'b1);
    add("release",      3'b111, 3'b000, 2'd2, 5, 9'h000, 3'b010, 2'd2, 1'b0, 1'b1);
    add("released",     3'b111, 3'b000, 2'd2, 3, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    // 3-cycle glitch is rejected
    add("glitch3",      3'b110, 3'b000, 2'd2, 3, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    add("glitch3_end",  3'b111, 3'b000, 2'd2, 8, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    // 4-cycle low is exactly long enough to count as a press
    add("low4",         3'b110, 3'b000, 2'd2, 4, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    add("low4_end",     3'b111, 3'b000, 2'd2, 1, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    add("low4_edge",    3'b111, 3'b000, 2'd2, 1, 9'h040, 3'b001, 2'd2, 1'b0, 1'b1);
    add("low4_held",    3'b111, 3'b000, 2'd2, 3, 9'h000, 3'b001, 2'd2, 1'b0, 1'b1);
    add("low4_rel",     3'b111, 3'b000, 2'd2, 3, 9'h000, 3'b000, 2'd2, 1'b0, 1'b1);
    // Out-of-range consumer drops pulses but still debounces
    add("bad_sel",      3'b111, 3'b000, 2'd3, 1, 9'h000, 3'b000, 2'd3, 1'b0, 1'b0);
    add("bad_press",    3'b011, 3'b000, 2'd3, 5, 9'h000, 3'b000, 2'd3, 1'b0, 1'b0);
    add("bad_level",    3'b011, 3'b000, 2'd3, 2, 9'h000, 3'b100, 2'd3, 1'b0, 1'b0);
    add("bad_rel",      3'b111, 3'b000, 2'd3, 5, 9'h000, 3'b100, 2'd3, 1'b0, 1'b0);
    add("bad_relz",     3'b111, 3'b000, 2'd3, 2, 9'h000, 3'b000, 2'd3, 1'b0, 1'b0);
    add("back_to_0",    3'b111, 3'b000, 2'd0, 1, 9'h000, 3'b000, 2'd0, 1'b0, 1'b1);

    // Reset state
    rst = 1'b0; btn_raw = 3'b111; repeat_en = 3'b000; dest_sel = 2'd2;
    #2;
    check("reset_async", pack_exp(9'h000, 3'b000, 2'd0, 1'b1, 1'b1));
    step(); step();
    check("reset_hold", pack_exp(9'h000, 3'b000, 2'd0, 1'b1, 1'b1));
    rst = 1'b1;
    step();
    check("first_switch", pack_exp(9'h000, 3'b000, 2'd2, 1'b0, 1'b1));
    step();

    foreach (tbl[r]) begin
      btn_raw = tbl[r].raw; repeat_en = tbl[r].ren; dest_sel = tbl[r].sel;
      for (int c = 0; c < tbl[r].n; c++) begin
        step();
        check($sformatf("%s[%0d]", tbl[r].name, c),
              pack_exp(tbl[r].pulse, tbl[r].level, tbl[r].act, tbl[r].pend, tbl[r].valid));
      end
    end

    // Auto-repeat on button 2, consumer 0: press at P, repeats P+20, P+28, enable dropped at P+30
    btn_raw = 3'b011; repeat_en = 3'b100; dest_sel = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("rep_press[%0d]", k),
            pack_exp((k == 6) ? 9'h004 : 9'h000, (k == 6) ? 3'b100 : 3'b000, 2'd0, 1'b0, 1'b1));
    end
    for (int k = 1; k <= 40; k++) begin
      if (k == 31) repeat_en = 3'b000;
      step();
      check($sformatf("repeat[P+%0d]", k),
            pack_exp((k == 20 || k == 28) ? 9'h004 : 9'h000, 3'b100, 2'd0, 1'b0, 1'b1));
    end

    // Deferred switch: request consumer 1 while held; repeats stay on consumer 0
    repeat_en = 3'b100; dest_sel = 2'd1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("defer[%0d]", k),
            pack_exp((k == 20) ? 9'h004 : 9'h000, 3'b100, 2'd0, 1'b1, 1'b1));
    end
    btn_raw = 3'b111; repeat_en = 3'b000;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("defer_rel[%0d]", k),
            pack_exp(9'h000, (k < 6) ? 3'b100 : 3'b000, (k < 7) ? 2'd0 : 2'd1,
                     (k < 7) ? 1'b1 : 1'b0, 1'b1));
    end
    btn_raw = 3'b110; repeat_en = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("new_dest[%0d]", k),
            pack_exp((k == 6) ? 9'h008 : 9'h000, (k == 6) ? 3'b001 : 3'b000, 2'd1, 1'b0, 1'b1));
    end
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("rep_b0[%0d]", k),
            pack_exp((k == 20) ? 9'h008 : 9'h000, 3'b001, 2'd1, 1'b0, 1'b1));
    end

    // Reset during REPEAT with button still held; dest_sel=1 so pending shows while in reset
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_async", pack_exp(9'h000, 3'b000, 2'd0, 1'b1, 1'b1));
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("rst_mid_hold[%0d]", k), pack_exp(9'h000, 3'b000, 2'd0, 1'b1, 1'b1));
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("post_rst[%0d]", k),
            pack_exp((k == 6) ? 9'h008 : 9'h000, (k == 6) ? 3'b001 : 3'b000, 2'd1, 1'b0, 1'b1));
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      check($sformatf("post_rst_held[%0d]", k), pack_exp(9'h000, 3'b001, 2'd1, 1'b0, 1'b1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
